sync_fifo_flex: RTL

Next-generation single-clock FIFO. It supports any depth (not only powers of two), selectable standard or first-word-fall-through (FWFT) read mode, and an occupancy count. It also has programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It is a drop-in buffer between same-clock producer/consumer blocks such as UART, stream and DMA paths.

---
 rtl/sync_fifo_ptr.sv | 34 +++
 rtl/sync_fifo_flex.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sync_fifo_ptr.sv
// Wrapping pointer for a FIFO of arbitrary depth: counts 0..DEPTH-1, then back to 0.
// Flush (rst or clr) returns it to 0 on the next edge; inc is ignored that cycle.
module sync_fifo_ptr #(
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] r_ptr;
  logic          w_at_last;

  // An explicit compare against DEPTH-1 makes non-power-of-two depths wrap exactly.
  assign w_at_last = (r_ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      if (w_at_last) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= r_ptr + PW'(1);
      end
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO of any depth with standard or first-word-fall-through reads,
// occupancy count, programmable almost flags, synchronous flush and sticky error flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  generate
    if (FIFO_DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH ||
        AE_THRESH < 0 || AE_THRESH > FIFO_DEPTH - 1) begin : g_param_err
      $error("sync_fifo_flex: illegal FIFO_DEPTH/AF_THRESH/AE_THRESH combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
  logic [CW-1:0]         r_count;
  logic                  r_overflow;
  logic                  r_underflow;
  logic [PW-1:0]         w_wr_ptr;
  logic [PW-1:0]         w_rd_ptr;
  logic                  w_flush;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  assign w_flush = rst | clr;

  // Acceptance looks only at the registered count: no full-bypass or empty-bypass.
  assign w_wr_acc = wr_en & ~full  & ~w_flush;
  assign w_rd_acc = rd_en & ~empty & ~w_flush;

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_wr_acc),
    .ptr (w_wr_ptr)
  );

  sync_fifo_ptr #(.DEPTH(FIFO_DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_rd_acc),
    .ptr (w_rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Error flags see the raw requests, so a rejected access in any state is recorded.
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = r_mem[w_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;

      // clr deliberately keeps the last word; only rst clears the output register.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rd_data <= '0;
        end else if (w_rd_acc) begin
          r_rd_data <= r_mem[w_rd_ptr];
        end
      end

      assign rd_data = r_rd_data;
    end
  endgenerate

  assign count        = r_count;
  assign full         = (r_count == CW'(FIFO_DEPTH));
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
